// File: rtl/rect_sprite_pixel_source.sv
// rect_sprite_pixel_source: clipped rectangle fill / 1bpp sprite pixel streamer feeding the framebuffer burst writer
module rect_sprite_pixel_source #(
   parameter int SCREEN_W = 800,
   parameter int SCREEN_H = 600,
   parameter int BM_AW    = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [10:0]      cmd_x,
   input  logic [10:0]      cmd_y,
   input  logic [10:0]      cmd_w,
   input  logic [10:0]      cmd_h,
   input  logic [1:0]       cmd_mode,
   input  logic [7:0]       cmd_fg,
   input  logic [7:0]       cmd_bg,
   input  logic [BM_AW-1:0] cmd_bm_base,
   output logic [BM_AW-1:0] bm_addr,
   output logic             bm_en,
   input  logic [15:0]      bm_rdata,
   output logic [10:0]      pixel_x,
   output logic [10:0]      pixel_y,
   output logic [10:0]      width,
   output logic [10:0]      height,
   output logic [7:0]       pixel_data,
   output logic             draw,
   output logic             pixel_valid,
   input  logic             pixel_ready,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, PREP, RUN, DRAIN} state_t;
   state_t state, state_n;
   logic [10:0] x_q, y_q, w_q, c, r, fr;
   logic [1:0] mode_q, wcnt, fcnt;
   logic [7:0] fg_q, bg_q;
   logic [BM_AW-1:0] base_q, frow, stride;
   logic [11:0] cw, ch, cwm1, chm1, sw, sh, cw_n, ch_n;
   logic off, empty, sprite, pop, gen, cons, c_last, r_last, bit_v, issue, pend, fdone, stream_on;
   logic [6:0] fw;
   logic [15:0] wq0, wq1;
   logic [2:0] occ;
   logic [30:0] f0, f1, pix;

   assign sw = 12'(SCREEN_W) - {1'b0, cmd_x};
   assign sh = 12'(SCREEN_H) - {1'b0, cmd_y};
   assign off = {1'b0, cmd_x} >= 12'(SCREEN_W) || {1'b0, cmd_y} >= 12'(SCREEN_H);
   assign cw_n = off ? 12'd0 : ({1'b0, cmd_w} < sw ? {1'b0, cmd_w} : sw);
   assign ch_n = off ? 12'd0 : ({1'b0, cmd_h} < sh ? {1'b0, cmd_h} : sh);
   assign cwm1 = cw - 12'd1;
   assign chm1 = ch - 12'd1;
   assign empty = cw == 12'd0 || ch == 12'd0;
   assign stride = BM_AW'(({1'b0, w_q} + 12'd15) >> 4);
   assign sprite = mode_q == 2'd1 || mode_q == 2'd2;
   assign pop = pixel_valid && pixel_ready;
   assign c_last = {1'b0, c} == cwm1;
   assign r_last = {1'b0, r} == chm1;
   assign gen = state == RUN && (!sprite || wcnt != 2'd0) && (fcnt != 2'd2 || pop);
   assign cons = gen && sprite && (c[3:0] == 4'hf || c_last);
   assign bit_v = wq0[c[3:0]];
   assign pix = {x_q + c, y_q + r, (mode_q == 2'd2 && !bit_v) ? bg_q : fg_q, mode_q == 2'd1 ? bit_v : 1'b1};
   assign occ = 3'(wcnt) + 3'(pend) - 3'(cons);
   assign issue = state == RUN && sprite && !fdone && occ < 3'd2;
   assign bm_en = issue;
   assign bm_addr = frow + BM_AW'(fw);
   assign pixel_valid = fcnt != 2'd0 && (stream_on || fcnt == 2'd2 || state == DRAIN);
   assign {pixel_x, pixel_y, pixel_data, draw} = f0;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_n;
   end

   // next state: an empty clip finishes straight from PREP, the last generated pixel moves to DRAIN
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (cmd_valid) state_n = PREP;
         PREP:    state_n = empty ? IDLE : RUN;
         RUN:     if (gen && c_last && r_last) state_n = DRAIN;
         DRAIN:   if (fcnt == 2'd0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // control outputs; clip dimensions are only exposed while a job is live
   always_comb begin
      cmd_ready = state == IDLE;
      busy = state != IDLE;
      done = (state == PREP && empty) || (state == DRAIN && fcnt == 2'd0);
      width = busy ? cw[10:0] : 11'd0;
      height = busy ? ch[10:0] : 11'd0;
   end

   // latch the command and its clipped extent on handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {x_q, y_q, w_q, mode_q, fg_q, bg_q, base_q, cw, ch} <= '0;
      end else if (cmd_valid && cmd_ready) begin
         {x_q, y_q, w_q, mode_q, fg_q, bg_q, base_q} <= {cmd_x, cmd_y, cmd_w, cmd_mode, cmd_fg, cmd_bg, cmd_bm_base};
         {cw, ch} <= {cw_n, ch_n};
      end
   end

   // row-major pixel walk; stream_on keeps pixel_valid up once the burst has started
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {c, r, stream_on} <= '0;
      end else if (state == PREP) begin
         {c, r, stream_on} <= '0;
      end else begin
         stream_on <= stream_on || pixel_valid;
         if (gen) begin
            c <= c_last ? 11'd0 : c + 11'd1;
            r <= c_last ? r + 11'd1 : r;
         end
      end
   end

   // word fetcher: walks only the words covering the clipped columns, restarting at word 0 every row
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {frow, fw, fr, fdone, pend} <= '0;
      end else if (state == PREP) begin
         frow <= base_q;
         {fw, fr, fdone, pend} <= '0;
      end else begin
         pend <= issue;
         if (issue) begin
            fw <= fw == cwm1[10:4] ? 7'd0 : fw + 7'd1;
            frow <= fw == cwm1[10:4] ? frow + stride : frow;
            fr <= fw == cwm1[10:4] ? fr + 11'd1 : fr;
            fdone <= fw == cwm1[10:4] && {1'b0, fr} == chm1;
         end
      end
   end

   // two-word buffer: wq0 is the word being drawn, wq1 the prefetched successor
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {wq0, wq1, wcnt} <= '0;
      end else if (state == PREP) begin
         wcnt <= 2'd0;
      end else begin
         wcnt <= wcnt - 2'(cons) + 2'(pend);
         if (cons) wq0 <= wq1;
         if (pend && wcnt - 2'(cons) == 2'd0) wq0 <= bm_rdata;
         if (pend && wcnt - 2'(cons) != 2'd0) wq1 <= bm_rdata;
      end
   end

   // two-entry output FIFO, f0 is the head presented downstream
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         {f0, f1, fcnt} <= '0;
      end else begin
         fcnt <= fcnt - 2'(pop) + 2'(gen);
         if (pop) f0 <= f1;
         if (gen && fcnt - 2'(pop) == 2'd0) f0 <= pix;
         if (gen && fcnt - 2'(pop) != 2'd0) f1 <= pix;
      end
   end
endmodule

// File: tb/tb_rect_sprite_pixel_source.sv
// tb_rect_sprite_pixel_source: scoreboard bench for the rectangle / sprite pixel source
module tb_rect_sprite_pixel_source;
   localparam int BM_AW = 12;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_ready;
   logic [10:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
   logic [1:0] cmd_mode = '0;
   logic [7:0] cmd_fg = '0, cmd_bg = '0;
   logic [BM_AW-1:0] cmd_bm_base = '0;
   logic [BM_AW-1:0] bm_addr;
   logic bm_en;
   logic [15:0] bm_rdata = '0;
   logic [10:0] pixel_x, pixel_y, width, height;
   logic [7:0] pixel_data;
   logic draw, pixel_valid, busy, done;
   logic pixel_ready = 1'b1;

   int errors = 0, checks = 0;
   logic [30:0] sb[$];
   logic [BM_AW-1:0] rd_exp[$];
   logic [15:0] mem [0:4095];
   int pop_total = 0, rise_total = 0, done_total = 0, vcyc_total = 0, pops_at_done = 0;
   logic [10:0] last_w = '0, last_h = '0;
   logic prev_valid = 1'b0, prev_ready = 1'b0;
   logic [30:0] prev_head = '0, exp_px;
   logic [7:0] pat = 8'hFF;
   int pat_len = 1, pat_idx = 0;
   logic [30:0] head;
   logic [69:0] outs;
   localparam logic [69:0] RESET_OUTS = {1'b1, 69'd0};

   assign head = {pixel_x, pixel_y, pixel_data, draw};
   assign outs = {cmd_ready, busy, done, pixel_valid, bm_en, bm_addr, width, height, pixel_x, pixel_y, pixel_data, draw};

   rect_sprite_pixel_source #(.SCREEN_W(800), .SCREEN_H(600), .BM_AW(BM_AW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_mode(cmd_mode),
      .cmd_fg(cmd_fg), .cmd_bg(cmd_bg), .cmd_bm_base(cmd_bm_base),
      .bm_addr(bm_addr), .bm_en(bm_en), .bm_rdata(bm_rdata),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .width(width), .height(height),
      .pixel_data(pixel_data), .draw(draw), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   // bitmap RAM with one cycle of read latency
   always @(posedge clk) if (bm_en) bm_rdata <= mem[bm_addr];

   // downstream ready follows a cyclic pattern
   always @(posedge clk) begin
      #1;
      pixel_ready = pat[3'(pat_idx % pat_len)];
      pat_idx = pat_idx + 1;
   end

   // monitor: pops pixels and bitmap reads against the scoreboards, tracks valid continuity
   always @(negedge clk) begin
      if (!reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (bm_en) begin
            checks++;
            if (rd_exp.size() == 0) begin
               errors++;
               $display("FAIL bm_read: got addr=%h, none expected", bm_addr);
            end else if (bm_addr !== rd_exp[0]) begin
               errors++;
               $display("FAIL bm_read: got addr=%h want %h", bm_addr, rd_exp[0]);
               void'(rd_exp.pop_front());
            end else void'(rd_exp.pop_front());
         end
         if (done) begin
            done_total++;
            pops_at_done = pop_total;
         end
         if (pixel_valid) vcyc_total++;
         if (pixel_valid && !prev_valid) rise_total++;
         if (pixel_valid && prev_valid && !prev_ready) begin
            checks++;
            if (head !== prev_head) begin
               errors++;
               $display("FAIL head_stable: got %h want %h", head, prev_head);
            end
         end
         if (pixel_valid && pixel_ready) begin
            pop_total++;
            last_w = width;
            last_h = height;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL pixel: got x=%0d y=%0d d=%h dr=%b, none expected", pixel_x, pixel_y, pixel_data, draw);
            end else begin
               exp_px = sb.pop_front();
               if (head !== exp_px)
                  begin
                     errors++;
                     $display("FAIL pixel: got x=%0d y=%0d d=%h dr=%b want x=%0d y=%0d d=%h dr=%b",
                        pixel_x, pixel_y, pixel_data, draw, exp_px[30:20], exp_px[19:9], exp_px[8:1], exp_px[0]);
                  end
            end
         end
         prev_valid = pixel_valid;
         prev_ready = pixel_ready;
         prev_head = head;
      end
   end

   task automatic expect_job(input int x, input int y, input int w, input int h, input int mode,
                             input logic [7:0] fg, input logic [7:0] bg, input int base);
      int cw, ch, stride;
      logic [15:0] wd;
      logic b;
      cw = (x >= 800 || y >= 600) ? 0 : ((w < 800 - x) ? w : 800 - x);
      ch = (x >= 800 || y >= 600) ? 0 : ((h < 600 - y) ? h : 600 - y);
      stride = (w + 15) / 16;
      for (int rr = 0; rr < ch; rr++) begin
         if ((mode == 1 || mode == 2) && cw > 0)
            for (int j = 0; j <= (cw - 1) / 16; j++) rd_exp.push_back(BM_AW'(base + rr * stride + j));
         for (int cc = 0; cc < cw; cc++) begin
            wd = mem[base + rr * stride + cc / 16];
            b = (mode == 1 || mode == 2) ? wd[cc % 16] : 1'b1;
            sb.push_back({11'(x + cc), 11'(y + rr), (mode == 2 && !b) ? bg : fg, (mode == 1) ? b : 1'b1});
         end
      end
   endtask

   task automatic send_cmd(input int x, input int y, input int w, input int h, input int mode,
                           input logic [7:0] fg, input logic [7:0] bg, input int base);
      int n = 0;
      expect_job(x, y, w, h, mode, fg, bg, base);
      @(posedge clk); #1;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!cmd_ready) begin
         $display("FAIL cmd_ready_timeout: got 0 want 1");
         $fatal(1);
      end
      {cmd_x, cmd_y, cmd_w, cmd_h} = {11'(x), 11'(y), 11'(w), 11'(h)};
      {cmd_mode, cmd_fg, cmd_bg, cmd_bm_base} = {2'(mode), fg, bg, BM_AW'(base)};
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int start = done_total, n = 0;
      while (done_total == start && n < limit) begin @(posedge clk); n++; end
      checks++;
      if (done_total == start) begin
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles", limit);
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (outs !== RESET_OUTS) begin errors++; $display("FAIL reset_outputs: got %h want %h", outs, RESET_OUTS); end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_fill();
      int p0 = pop_total, r0 = rise_total, d0 = done_total;
      send_cmd(10, 20, 3, 2, 0, 8'h5A, 8'h00, 0);
      wait_done(200);
      checks++; if (pop_total - p0 != 6) begin errors++; $display("FAIL fill_pops: got %0d want 6", pop_total - p0); end
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL fill_done: got %0d want 1", done_total - d0); end
      checks++; if (pops_at_done - p0 != 6) begin errors++; $display("FAIL fill_done_order: got %0d want 6", pops_at_done - p0); end
      checks++; if (rise_total - r0 != 1) begin errors++; $display("FAIL fill_gap: got %0d rises want 1", rise_total - r0); end
      checks++; if ({last_w, last_h} !== {11'd3, 11'd2}) begin errors++; $display("FAIL fill_dims: got %0d x %0d want 3 x 2", last_w, last_h); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL fill_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_sprite_transparent();
      int p0 = pop_total, r0 = rise_total, v0 = vcyc_total;
      mem[12'h100] = 16'h0001;
      mem[12'h101] = 16'h000F;
      send_cmd(100, 50, 20, 1, 1, 8'h33, 8'h44, 12'h100);
      wait_done(300);
      checks++; if (pop_total - p0 != 20) begin errors++; $display("FAIL spr1_pops: got %0d want 20", pop_total - p0); end
      checks++; if (vcyc_total - v0 != 20) begin errors++; $display("FAIL spr1_valid_cycles: got %0d want 20", vcyc_total - v0); end
      checks++; if (rise_total - r0 != 1) begin errors++; $display("FAIL spr1_gap: got %0d rises want 1", rise_total - r0); end
      checks++; if (rd_exp.size() != 0) begin errors++; $display("FAIL spr1_reads: got %0d missing want 0", rd_exp.size()); end
   endtask

   task automatic test_clip();
      int p0 = pop_total, r0, d0;
      send_cmd(795, 5, 10, 1, 0, 8'h77, 8'h00, 0);
      wait_done(200);
      checks++; if (pop_total - p0 != 5) begin errors++; $display("FAIL clip_x_pops: got %0d want 5", pop_total - p0); end
      checks++; if (last_w !== 11'd5) begin errors++; $display("FAIL clip_x_width: got %0d want 5", last_w); end
      p0 = pop_total;
      send_cmd(0, 598, 2, 5, 0, 8'h12, 8'h00, 0);
      wait_done(200);
      checks++; if (pop_total - p0 != 4 || last_h !== 11'd2) begin errors++; $display("FAIL clip_y: got %0d pops h=%0d want 4 pops h=2", pop_total - p0, last_h); end
      p0 = pop_total; r0 = rise_total; d0 = done_total;
      send_cmd(800, 5, 10, 1, 0, 8'h77, 8'h00, 0);
      wait_done(50);
      checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL clip_empty_done: got %0d want 1", done_total - d0); end
      checks++; if (rise_total - r0 != 0 || pop_total - p0 != 0) begin errors++; $display("FAIL clip_empty_valid: got %0d rises want 0", rise_total - r0); end
   endtask

   task automatic test_backpressure();
      int p0 = pop_total, r0 = rise_total, d0 = done_total;
      pat = 8'b0101_1001;
      pat_len = 7;
      send_cmd(200, 300, 4, 1, 0, 8'hC3, 8'h00, 0);
      wait_done(300);
      checks++; if (pop_total - p0 != 4) begin errors++; $display("FAIL bp_pops: got %0d want 4", pop_total - p0); end
      checks++; if (pops_at_done - p0 != 4 || done_total - d0 != 1) begin errors++; $display("FAIL bp_done: got %0d pops before done want 4", pops_at_done - p0); end
      checks++; if (rise_total - r0 != 1) begin errors++; $display("FAIL bp_gap: got %0d rises want 1", rise_total - r0); end
      p0 = pop_total; r0 = rise_total;
      mem[12'h180] = 16'hF0F0; mem[12'h181] = 16'h0003; mem[12'h182] = 16'h1234; mem[12'h183] = 16'h0002;
      send_cmd(60, 70, 20, 2, 2, 8'hAA, 8'h55, 12'h180);
      wait_done(500);
      checks++; if (pop_total - p0 != 40 || rise_total - r0 != 1) begin errors++; $display("FAIL bp_sprite: got %0d pops %0d rises want 40 pops 1 rise", pop_total - p0, rise_total - r0); end
      pat = 8'hFF;
      pat_len = 1;
   endtask

   task automatic test_opaque();
      int p0 = pop_total, r0 = rise_total;
      mem[12'h200] = 16'hA5C3; mem[12'h201] = 16'h0001; mem[12'h202] = 16'h3C0F; mem[12'h203] = 16'h0000;
      send_cmd(30, 40, 17, 2, 2, 8'hFF, 8'h00, 12'h200);
      wait_done(300);
      checks++; if (pop_total - p0 != 34) begin errors++; $display("FAIL opq_pops: got %0d want 34", pop_total - p0); end
      checks++; if (rise_total - r0 != 1) begin errors++; $display("FAIL opq_gap: got %0d rises want 1", rise_total - r0); end
      checks++; if (rd_exp.size() != 0) begin errors++; $display("FAIL opq_reads: got %0d missing want 0", rd_exp.size()); end
   endtask

   task automatic test_reset_midrun();
      int p0 = pop_total, d0, n = 0;
      send_cmd(0, 0, 20, 3, 0, 8'h11, 8'h00, 0);
      while (pop_total < p0 + 5 && n < 200) begin @(posedge clk); n++; end
      checks++; if (pop_total < p0 + 5) begin errors++; $display("FAIL rst_wait: got %0d pops want 5", pop_total - p0); end
      #3 reset = 1'b0;
      d0 = done_total;
      #1;
      checks++; if (outs !== RESET_OUTS) begin errors++; $display("FAIL rst_async: got %h want %h", outs, RESET_OUTS); end
      repeat (2) @(posedge clk);
      sb.delete();
      rd_exp.delete();
      @(negedge clk) reset = 1'b1;
      repeat (3) @(posedge clk);
      checks++; if (done_total != d0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_total - d0); end
      p0 = pop_total;
      mem[12'h300] = 16'h8421; mem[12'h301] = 16'h0002; mem[12'h302] = 16'h7E7E; mem[12'h303] = 16'h0001;
      send_cmd(400, 100, 18, 2, 1, 8'h9C, 8'h00, 12'h300);
      wait_done(300);
      checks++; if (pop_total - p0 != 36 || sb.size() != 0) begin errors++; $display("FAIL rst_rerun: got %0d pops want 36", pop_total - p0); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
      test_reset();
      test_fill();
      test_sprite_transparent();
      test_clip();
      test_backpressure();
      test_opaque();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
